// File: rtl/tqvp_dlmiles_i2c_pkg.sv
// Shared types and helpers for the TinyQV I2C pin multiplexer: FSM states,
// cfg_inv bit positions and the released (idle) pad level.
package tqvp_dlmiles_i2c_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SETTLE = 1'b1
    } iomux_state_e;

    localparam int INV_SCL_O  = 0;
    localparam int INV_SDA_O  = 1;
    localparam int INV_SCL_OE = 2;
    localparam int INV_SDA_OE = 3;

    // Returns {oe, o}: a released pad never drives low, so pull-down mode idles at 0
    // and direct mode idles high, with output enable off, both before inversion.
    function automatic logic [1:0] released_level(input logic direct,
                                                  input logic inv_o,
                                                  input logic inv_oe);
        return {inv_oe, direct ^ inv_o};
    endfunction

endpackage

// File: rtl/tqvp_dlmiles_i2c_line_filter.sv
// One I2C line: 2-FF synchroniser, optional glitch filter (TQVP_DLMILES_I2C_IOMUX_FILTER_EN)
// and a one-cycle delayed copy of the filtered level for edge detection.
module tqvp_dlmiles_i2c_line_filter #(
    parameter int FILT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pin_i,
    input  logic [FILT_W-1:0] filt_i,
    input  logic              hold_i,
    input  logic              reload_i,
    output logic              level_o,
    output logic              level_dly_o
);

    logic sync1_q, sync2_q;
    logic level_q, level_d;
    logic levelDly_q;

`ifdef TQVP_DLMILES_I2C_IOMUX_FILTER_EN
    logic [FILT_W-1:0] cnt_q, cnt_d;

    // Accept a new level only after it has disagreed for filt_i+1 samples in a row.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (reload_i) begin
            level_d = sync2_q;
        end else if (!hold_i && (sync2_q != level_q)) begin
            if (cnt_q >= filt_i) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_filt;
    assign unused_filt = ^filt_i;

    always_comb begin
        level_d = level_q;
        if (reload_i || !hold_i) begin
            level_d = sync2_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            level_q    <= 1'b1;
            levelDly_q <= 1'b1;
        end else begin
            sync1_q    <= pin_i;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            levelDly_q <= reload_i ? sync2_q : level_q;
        end
    end

    assign level_o     = level_q;
    assign level_dly_o = levelDly_q;

endmodule

// File: rtl/tqvp_dlmiles_i2c_iomux.sv
// I2C pad multiplexer between TinyQV pins and the I2C controller: input select and
// conditioning, registered pad drive, settle window on config change.
// Glitch filter enabled by defining TQVP_DLMILES_I2C_IOMUX_FILTER_EN.
module tqvp_dlmiles_i2c_iomux
    import tqvp_dlmiles_i2c_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int FILT_W        = 3,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [$clog2(NUM_PORTS)-1:0] cfg_in_sel,
    input  logic [NUM_PORTS-1:0]         cfg_out_en,
    input  logic [1:0]                   cfg_direct,
    input  logic [3:0]                   cfg_inv,
    input  logic [FILT_W-1:0]            cfg_filt,
    input  logic [NUM_PORTS-1:0]         pin_scl,
    input  logic [NUM_PORTS-1:0]         pin_sda,
    output logic [NUM_PORTS-1:0]         uo_scl,
    output logic [NUM_PORTS-1:0]         uo_sda,
    output logic [NUM_PORTS-1:0]         uo_scl_oe,
    output logic [NUM_PORTS-1:0]         uo_sda_oe,
    input  logic                         scl_o,
    input  logic                         scl_oe,
    input  logic                         sda_o,
    input  logic                         sda_oe,
    output logic                         scl_i,
    output logic                         sda_i,
    output logic                         scl_rise,
    output logic                         scl_fall,
    output logic                         sda_rise,
    output logic                         sda_fall,
    output logic                         start_det,
    output logic                         stop_det,
    output logic                         cfg_busy
);

    localparam int SEL_W = $clog2(NUM_PORTS);
    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam int CFG_W = SEL_W + NUM_PORTS + 6;
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    iomux_state_e     state_q, state_d;
    logic [CNT_W-1:0] settleCnt_q, settleCnt_d;
    logic [CFG_W-1:0] cfgLive, cfgShadow_q;
    logic             shadowValid_q;
    logic             cfgChange;

    // The first sample after reset only primes the shadow so reset's own settle is not stretched.
    assign cfgLive   = {cfg_in_sel, cfg_out_en, cfg_direct, cfg_inv};
    assign cfgChange = shadowValid_q && (cfgLive != cfgShadow_q);

    always_comb begin
        state_d     = state_q;
        settleCnt_d = settleCnt_q;
        case (state_q)
            ST_RUN: begin
                if (cfgChange) begin
                    state_d     = ST_SETTLE;
                    settleCnt_d = SETTLE_LOAD;
                end
            end
            ST_SETTLE: begin
                if (cfgChange) begin
                    settleCnt_d = SETTLE_LOAD;
                end else if (settleCnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    settleCnt_d = settleCnt_q - 1'b1;
                end
            end
            default: state_d = ST_SETTLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_SETTLE;
            settleCnt_q   <= SETTLE_LOAD;
            cfgShadow_q   <= '0;
            shadowValid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            settleCnt_q   <= settleCnt_d;
            cfgShadow_q   <= cfgLive;
            shadowValid_q <= 1'b1;
        end
    end

    logic                 sclDrive, sdaDrive;
    logic [1:0]           sclRel, sdaRel;
    logic [NUM_PORTS-1:0] relPort;
    logic [NUM_PORTS-1:0] uoScl_q, uoSda_q, uoSclOe_q, uoSdaOe_q;
    logic [NUM_PORTS-1:0] uoScl_d, uoSda_d, uoSclOe_d, uoSdaOe_d;

    assign sclDrive = cfg_direct[0] ? scl_o : (scl_oe & ~scl_o);
    assign sdaDrive = cfg_direct[1] ? sda_o : (sda_oe & ~sda_o);
    assign sclRel   = released_level(cfg_direct[0], cfg_inv[INV_SCL_O], cfg_inv[INV_SCL_OE]);
    assign sdaRel   = released_level(cfg_direct[1], cfg_inv[INV_SDA_O], cfg_inv[INV_SDA_OE]);
    assign relPort  = ~cfg_out_en | {NUM_PORTS{state_d == ST_SETTLE}};

    always_comb begin
        uoScl_d   = '0;
        uoSda_d   = '0;
        uoSclOe_d = '0;
        uoSdaOe_d = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            uoScl_d[p]   = relPort[p] ? sclRel[0] : (sclDrive ^ cfg_inv[INV_SCL_O]);
            uoSclOe_d[p] = relPort[p] ? sclRel[1] : (scl_oe ^ cfg_inv[INV_SCL_OE]);
            uoSda_d[p]   = relPort[p] ? sdaRel[0] : (sdaDrive ^ cfg_inv[INV_SDA_O]);
            uoSdaOe_d[p] = relPort[p] ? sdaRel[1] : (sda_oe ^ cfg_inv[INV_SDA_OE]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uoScl_q   <= '0;
            uoSda_q   <= '0;
            uoSclOe_q <= '0;
            uoSdaOe_q <= '0;
        end else begin
            uoScl_q   <= uoScl_d;
            uoSda_q   <= uoSda_d;
            uoSclOe_q <= uoSclOe_d;
            uoSdaOe_q <= uoSdaOe_d;
        end
    end

    assign uo_scl    = uoScl_q;
    assign uo_sda    = uoSda_q;
    assign uo_scl_oe = uoSclOe_q;
    assign uo_sda_oe = uoSdaOe_q;

    logic lineHold, lineReload;
    logic sclLevel, sclDly, sdaLevel, sdaDly;
    logic running;

    // Lines freeze while settling and resynchronise on the way out so a port switch never pulses.
    assign lineHold   = (state_d == ST_SETTLE);
    assign lineReload = (state_q == ST_SETTLE) && (state_d == ST_RUN);

    tqvp_dlmiles_i2c_line_filter #(.FILT_W(FILT_W)) u_scl_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .pin_i      (pin_scl[cfg_in_sel]),
        .filt_i     (cfg_filt),
        .hold_i     (lineHold),
        .reload_i   (lineReload),
        .level_o    (sclLevel),
        .level_dly_o(sclDly)
    );

    tqvp_dlmiles_i2c_line_filter #(.FILT_W(FILT_W)) u_sda_filter (
        .clk        (clk),
        .rst_n      (rst_n),
        .pin_i      (pin_sda[cfg_in_sel]),
        .filt_i     (cfg_filt),
        .hold_i     (lineHold),
        .reload_i   (lineReload),
        .level_o    (sdaLevel),
        .level_dly_o(sdaDly)
    );

    assign running  = (state_q == ST_RUN);
    assign scl_i    = sclLevel;
    assign sda_i    = sdaLevel;
    assign scl_rise = running & sclLevel & ~sclDly;
    assign scl_fall = running & ~sclLevel & sclDly;
    assign sda_rise = running & sdaLevel & ~sdaDly;
    assign sda_fall = running & ~sdaLevel & sdaDly;

    // Qualify on the delayed SCL so a simultaneous SCL edge uses the pre-edge level.
    assign start_det = sda_fall & sclDly;
    assign stop_det  = sda_rise & sclDly;
    assign cfg_busy  = ~running;

endmodule
